display_scheduler: RTL and testbench
====================================

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 100000000, meaning clk cycles one requester owns the display (1 s at 100 MHz).
REQ-002 SHALL have parameter BIN_W, default 14, meaning width of each requester's unsigned binary value.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state is on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req, input, 3, per-requester display request (bit i = requester i).
REQ-006 SHALL have port values, input, 3*BIN_W, requester i value in bits [i*BIN_W +: BIN_W].
REQ-007 SHALL have port nums, output, 16, four BCD digits for the 4-digit segment driver; [3:0] is units and [15:12] is thousands.
REQ-008 SHALL have port grant, output, 3, one-hot owner of the currently displayed value; all-zero when there is no owner.
REQ-009 SHALL have port busy, output, 1, high while in the CONVERT state.

Function
REQ-010 SHALL implement FSM states IDLE, CONVERT, HOLD.
REQ-011 SHALL, in IDLE with req != 0, select the next requester round-robin, starting after the last owner (priority 0>1>2 after reset), latch its value, and enter CONVERT.
REQ-012 SHALL saturate a latched value >9999 to 9999 before conversion.
REQ-013 SHALL convert using shift-add-3 (double dabble), one bit per cycle, exactly BIN_W cycles in CONVERT.
REQ-014 SHALL update nums and grant together on the edge ending the last CONVERT cycle: the 15th rising edge after IDLE samples req (BIN_W=14), then enter HOLD.
REQ-015 SHALL never show partial conversion results on nums; nums changes only per REQ-014.
REQ-016 SHALL, in HOLD, count DWELL_CYCLES cycles; at terminal count, re-arbitrate as in REQ-011, with the owner considered last.
REQ-017 SHALL, when only the current owner still requests at terminal count, reconvert that owner's current value (refresh), keeping grant unchanged during conversion.
REQ-018 SHALL, when req == 0 at terminal count, clear grant, retain nums, and return to IDLE.
REQ-019 SHALL end HOLD early, on the cycle after the owner's req bit is sampled low, and then behave as at terminal count.
REQ-020 SHALL ignore req changes during CONVERT; the latched value and the selected requester are fixed.
REQ-021 SHALL, when new requests arrive during HOLD, not preempt the owner before terminal count or an early end.
REQ-022 SHALL hold grant one-hot or zero at all times.

Reset
REQ-023 SHALL, on rst high, immediately set nums=16'hFFFF (all digits blank), grant=0, busy=0, state=IDLE, dwell counter=0, and the round-robin pointer so that requester 0 has highest priority.
REQ-024 SHALL abort any conversion or hold in progress when rst asserts; nothing resumes after release.
REQ-025 SHALL sample req at the first rising edge after rst deasserts.

Structure
REQ-026 SHALL place the state enum, N_REQ=3, and the BCD digit count (4) in shared package display_pkg.
REQ-027 SHALL implement conversion in sub-module bin2bcd_seq (inputs start and bin; outputs done and bcd[15:0]); display_scheduler owns arbitration, dwell and output registers.

Verification (bench DWELL_CYCLES=8)
REQ-028 SHALL verify: reset, then req=3'b001 with value0=1234 -> busy high 14 cycles, nums=16'h1234 and grant=3'b001 on the 15th edge.
REQ-029 SHALL verify: value1=12000, req=3'b010 -> nums=16'h9999 (saturation).
REQ-030 SHALL verify: req=3'b111 held -> grant sequence 001,010,100,001, each lasting 8 HOLD cycles plus a 14-cycle conversion.
REQ-031 SHALL verify: owner 0 drops req at HOLD cycle 3 with req=3'b100 pending -> HOLD ends next cycle and the new grant is 3'b100 with value2 converted.
REQ-032 SHALL verify: only req0 held with value0 changed 42->7 during HOLD -> after dwell, refresh gives nums=16'h0007 and grant stays 001 throughout.
REQ-033 SHALL verify: rst asserted at CONVERT cycle 5 -> nums=16'hFFFF, grant=0 and busy=0 immediately; a fresh request afterwards gets the full 15-edge latency.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and helpers for the display scheduler: FSM states, requester
// count, digit count and the round-robin / one-hot helpers.
package display_pkg;

  typedef enum logic [1:0] {StIdle, StConvert, StHold} state_e;

  localparam int unsigned N_REQ    = 3;
  localparam int unsigned N_DIGITS = 4;
  localparam int unsigned BCD_MAX  = 9999;

  typedef logic [1:0] req_idx_t;

  // Nearest requester after 'last' wins; 'last' itself is considered last.
  function automatic req_idx_t rr_pick(input logic [N_REQ-1:0] req, input req_idx_t last);
    req_idx_t    idx;
    int unsigned pos;
    idx = last;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      pos = (32'(last) + k) % N_REQ;
      if (req[pos]) idx = req_idx_t'(pos);
    end
    return idx;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input req_idx_t idx);
    logic [N_REQ-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_REQ; i++) r[i] = (idx == req_idx_t'(i));
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bin bit per cycle.
// start loads bin; done is high in the cycle whose closing edge completes the
// last shift, and bcd carries that final result in the same cycle.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    done,
  output logic [4*N_DIGITS-1:0]   bcd
);

  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  logic [BIN_W-1:0]      bin_q;
  logic [4*N_DIGITS-1:0] bcd_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  active_q;

  logic [4*N_DIGITS-1:0] adj;
  logic [4*N_DIGITS-1:0] step_bcd;

  // Add 3 to every digit >= 5, then shift in the next binary MSB.
  always_comb begin
    adj = bcd_q;
    for (int unsigned d = 0; d < N_DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
    step_bcd = {adj[4*N_DIGITS-2:0], bin_q[BIN_W-1]};
  end

  assign done = active_q && (cnt_q == CNT_W'(BIN_W - 1));
  assign bcd  = step_bcd;

  // Shift register and step counter; a new start always wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      bin_q    <= bin;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      bin_q <= {bin_q[BIN_W-2:0], 1'b0};
      bcd_q <= step_bcd;
      cnt_q <= cnt_q + 1'b1;
      if (done) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares a 4-digit BCD display among three requesters. Round-robin
// arbitration, saturating sequential conversion, then a fixed dwell during
// which the owner keeps the display unless it withdraws its request.
module display_scheduler
  import display_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 100000000,
  parameter int unsigned BIN_W        = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*BIN_W-1:0]  values,
  output logic [4*N_DIGITS-1:0]   nums,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);

  localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  state_e                state_q;
  req_idx_t              sel_q;
  req_idx_t              last_q;
  logic [N_REQ-1:0]      grant_q;
  logic [4*N_DIGITS-1:0] nums_q;
  logic                  busy_q;
  logic [DW-1:0]         dwell_q;

  req_idx_t              arb_idx;
  logic [BIN_W-1:0]      arb_val;
  logic [BIN_W-1:0]      conv_bin;
  logic                  hold_end;
  logic                  conv_start;
  logic                  conv_done;
  logic [4*N_DIGITS-1:0] conv_bcd;

  assign arb_idx = rr_pick(req, last_q);

  // Value of the requester that would win arbitration now, saturated.
  always_comb begin
    arb_val = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_idx == req_idx_t'(i)) arb_val = values[i*BIN_W +: BIN_W];
    end
    conv_bin = (32'(arb_val) > BCD_MAX) ? BIN_W'(BCD_MAX) : arb_val;
  end

  // Dwell expires, or the owner has withdrawn its request.
  assign hold_end   = (dwell_q == DW'(DWELL_CYCLES - 1)) || !(|(req & grant_q));
  assign conv_start = (|req) && ((state_q == StIdle) || ((state_q == StHold) && hold_end));

  bin2bcd_seq #(
    .BIN_W(BIN_W)
  ) u_bin2bcd (
    .clk  (clk),
    .rst  (rst),
    .start(conv_start),
    .bin  (conv_bin),
    .done (conv_done),
    .bcd  (conv_bcd)
  );

  // Arbitration / dwell FSM with registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      last_q  <= req_idx_t'(N_REQ - 1);
      grant_q <= '0;
      nums_q  <= '1;
      busy_q  <= 1'b0;
      dwell_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (conv_start) begin
            sel_q   <= arb_idx;
            last_q  <= arb_idx;
            busy_q  <= 1'b1;
            state_q <= StConvert;
          end
        end
        StConvert: begin
          if (conv_done) begin
            nums_q  <= conv_bcd;
            grant_q <= onehot(sel_q);
            busy_q  <= 1'b0;
            dwell_q <= '0;
            state_q <= StHold;
          end
        end
        StHold: begin
          if (hold_end) begin
            dwell_q <= '0;
            if (conv_start) begin
              // Old grant stays visible until the new value is ready.
              sel_q   <= arb_idx;
              last_q  <= arb_idx;
              busy_q  <= 1'b1;
              state_q <= StConvert;
            end else begin
              grant_q <= '0;
              state_q <= StIdle;
            end
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign nums  = nums_q;
  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler with a short dwell.
module tb_display_scheduler;

  localparam int unsigned DWELL = 8;
  localparam int unsigned BW    = 14;
  localparam int unsigned CONV  = 14;
  localparam int unsigned PER   = DWELL + CONV;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [13:0] v [3];
  logic [41:0] values;
  logic [15:0] nums;
  logic [2:0]  grant;
  logic        busy;

  int n_tests;
  int n_fail;

  assign values = {v[2], v[1], v[0]};

  display_scheduler #(
    .DWELL_CYCLES(DWELL),
    .BIN_W       (BW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .values(values),
    .nums  (nums),
    .grant (grant),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    int          v0;
    int          v1;
    int          v2;
    logic [2:0]  exp_grant;
    logic [15:0] exp_nums;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference: saturate, then decimal digits by plain arithmetic.
  function automatic logic [15:0] ref_bcd(input int val);
    int s;
    logic [15:0] r;
    s = (val > 9999) ? 9999 : val;
    r[15:12] = 4'(s / 1000);
    r[11:8]  = 4'((s / 100) % 10);
    r[7:4]   = 4'((s / 10) % 10);
    r[3:0]   = 4'(s % 10);
    return r;
  endfunction

  function automatic int ref_rr(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return last;
  endfunction

  // Constant request pattern from reset: arbitration at edges 0, PER, 2*PER...,
  // display update CONV edges later; optionally mutate values along the way.
  task automatic run_sched(input logic [2:0] rq, input int ncyc, input bit mutate);
    int          last;
    int          pend_owner;
    int          pend_val;
    logic [2:0]  exp_g;
    logic [15:0] exp_n;
    do_reset();
    req        = rq;
    last       = 2;
    pend_owner = 0;
    pend_val   = 0;
    exp_g      = 3'b000;
    exp_n      = 16'hFFFF;
    for (int t = 0; t < ncyc; t++) begin
      if (t % PER == 0) begin
        pend_owner = ref_rr(rq, last);
        pend_val   = int'(v[pend_owner]);
        last       = pend_owner;
      end
      tick();
      if (t >= CONV && (t - CONV) % PER == 0) begin
        exp_g = 3'(1 << pend_owner);
        exp_n = ref_bcd(pend_val);
      end
      check("sched_grant", 32'(grant), 32'(exp_g));
      check("sched_nums", 32'(nums), 32'(exp_n));
      check("sched_busy", 32'(busy), 32'((t % PER) < CONV));
      if (mutate && $urandom_range(0, 5) == 0) v[$urandom_range(0, 2)] = 14'($urandom_range(0, 16383));
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    req     = 3'b000;
    v[0]    = '0;
    v[1]    = '0;
    v[2]    = '0;

    vecs[0] = '{3'b001, 1234, 0, 0, 3'b001, 16'h1234};
    vecs[1] = '{3'b010, 0, 12000, 0, 3'b010, 16'h9999};
    vecs[2] = '{3'b100, 5, 6, 0, 3'b100, 16'h0000};
    vecs[3] = '{3'b011, 4321, 77, 0, 3'b001, 16'h4321};
    vecs[4] = '{3'b110, 1, 808, 909, 3'b010, 16'h0808};
    vecs[5] = '{3'b001, 9999, 0, 0, 3'b001, 16'h9999};
    vecs[6] = '{3'b001, 10000, 0, 0, 3'b001, 16'h9999};
    vecs[7] = '{3'b100, 0, 0, 16383, 3'b100, 16'h9999};
    vecs[8] = '{3'b111, 5, 3, 2, 3'b001, 16'h0005};

    // Reset state
    do_reset();
    check("rst_nums", 32'(nums), 32'h0000FFFF);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // First-conversion latency and value from reset
    foreach (vecs[i]) begin
      do_reset();
      v[0] = 14'(vecs[i].v0);
      v[1] = 14'(vecs[i].v1);
      v[2] = 14'(vecs[i].v2);
      req  = vecs[i].req;
      for (int k = 1; k <= int'(CONV); k++) begin
        tick();
        check("vec_busy", 32'(busy), 32'd1);
      end
      check("vec_nums_early", 32'(nums), 32'h0000FFFF);
      check("vec_grant_early", 32'(grant), 32'd0);
      tick();
      check("vec_grant", 32'(grant), 32'(vecs[i].exp_grant));
      check("vec_nums", 32'(nums), 32'(vecs[i].exp_nums));
      check("vec_busy_done", 32'(busy), 32'd0);
    end

    // Full round-robin rotation 001,010,100,001
    v[0] = 14'd100;
    v[1] = 14'd200;
    v[2] = 14'd300;
    run_sched(3'b111, 3 * PER + CONV + 2, 1'b0);

    // Randomized request patterns and values
    for (int r = 0; r < 8; r++) begin
      for (int j = 0; j < 3; j++) v[j] = 14'($urandom_range(0, 16383));
      run_sched(3'($urandom_range(1, 7)), 4 * PER + CONV + 1, 1'b1);
    end

    // Owner drops at HOLD cycle 3 with requester 2 pending
    do_reset();
    v[0] = 14'd11;
    v[1] = 14'd0;
    v[2] = 14'd2222;
    req  = 3'b001;
    repeat (CONV + 1) tick();
    check("drop_nums0", 32'(nums), 32'h00000011);
    repeat (2) tick();
    req = 3'b100;
    tick();
    check("drop_busy", 32'(busy), 32'd1);
    check("drop_grant_hold", 32'(grant), 32'b001);
    repeat (CONV - 1) tick();
    check("drop_grant_late", 32'(grant), 32'b001);
    tick();
    check("drop_grant", 32'(grant), 32'b100);
    check("drop_nums", 32'(nums), 32'h00002222);

    // Refresh of a lone owner whose value changed during HOLD
    do_reset();
    v[0] = 14'd42;
    req  = 3'b001;
    repeat (CONV + 1) tick();
    check("refr_nums0", 32'(nums), 32'h00000042);
    for (int k = CONV + 2; k <= int'(PER + CONV + 1); k++) begin
      tick();
      if (k == CONV + 4) v[0] = 14'd7;
      check("refr_grant", 32'(grant), 32'b001);
      if (k == int'(PER + CONV)) check("refr_nums_old", 32'(nums), 32'h00000042);
    end
    check("refr_nums", 32'(nums), 32'h00000007);

    // Reset during refresh conversion cycle 5
    do_reset();
    v[0] = 14'd1234;
    req  = 3'b001;
    repeat (CONV + 1 + DWELL) tick();
    check("abort_busy_pre", 32'(busy), 32'd1);
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    check("abort_nums", 32'(nums), 32'h0000FFFF);
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    v[0] = 14'd567;
    for (int k = 1; k <= int'(CONV); k++) begin
      tick();
      check("abort_re_busy", 32'(busy), 32'd1);
    end
    check("abort_re_early", 32'(nums), 32'h0000FFFF);
    tick();
    check("abort_re_nums", 32'(nums), 32'h00000567);
    check("abort_re_grant", 32'(grant), 32'b001);

    // Dropping all requests during HOLD returns to idle, keeping nums
    req = 3'b000;
    tick();
    tick();
    check("idle_grant", 32'(grant), 32'd0);
    check("idle_nums", 32'(nums), 32'h00000567);
    check("idle_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
